cpu_rd_cache_adapter: RTL and testbench

//  CPU-side read adapter between the BPF CPU and the packet-memory read port.

---
 rtl/cpu_rd_cache_adapter_if.sv | 46 ++++
 rtl/cpu_rd_cache_adapter.sv | 190 +++++++++++++++++++
 tb/tb_cpu_rd_cache_adapter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_rd_cache_adapter_if.sv
// Bundle of CPU-side, memory-side and packet-handshake signals around the read cache adapter.
interface cpu_rd_cache_adapter_if #(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH      = 9,
  parameter int PLEN_WIDTH      = 32
);
  localparam int DATA_WIDTH = (2 ** (BYTE_ADDR_WIDTH - ADDR_WIDTH)) * 8;

  logic [BYTE_ADDR_WIDTH-1:0] byte_rd_addr;
  logic                       cpu_rd_en;
  logic [1:0]                 transfer_sz;
  logic                       cpu_acc;
  logic                       cpu_rej;
  logic                       rdy_for_cpu_ack;
  logic                       cpu_done_ack;
  logic                       rdy_for_cpu;
  logic                       busy;
  logic                       cache_hit;
  logic [31:0]                resized_mem_data;
  logic                       resized_mem_data_vld;
  logic [PLEN_WIDTH-1:0]      cpu_byte_len;
  logic [ADDR_WIDTH-1:0]      word_rd_addra;
  logic                       rd_en;
  logic                       acc;
  logic                       rej;
  logic                       rdy_ack;
  logic                       done_ack;
  logic                       rdy;
  logic [DATA_WIDTH-1:0]      bigword;
  logic                       bigword_vld;
  logic [PLEN_WIDTH-1:0]      byte_len;

  modport slave (
    input  byte_rd_addr, cpu_rd_en, transfer_sz, cpu_acc, cpu_rej, rdy_for_cpu_ack,
    input  done_ack, rdy, bigword, bigword_vld, byte_len,
    output cpu_done_ack, rdy_for_cpu, busy, cache_hit, resized_mem_data,
    output resized_mem_data_vld, cpu_byte_len, word_rd_addra, rd_en, acc, rej, rdy_ack
  );

  modport master (
    output byte_rd_addr, cpu_rd_en, transfer_sz, cpu_acc, cpu_rej, rdy_for_cpu_ack,
    output done_ack, rdy, bigword, bigword_vld, byte_len,
    input  cpu_done_ack, rdy_for_cpu, busy, cache_hit, resized_mem_data,
    input  resized_mem_data_vld, cpu_byte_len, word_rd_addra, rd_en, acc, rej, rdy_ack
  );
endinterface

// File: rtl/cpu_rd_cache_adapter.sv
// CPU read adapter: byte address + size -> word reads (one-line cache, straddling reads,
// variable memory latency), returning big-endian zero-padded W/H/B results.
module cpu_rd_cache_adapter #(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH      = 9,
  parameter int PLEN_WIDTH      = 32,
  parameter int CACHE_EN        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_rd_cache_adapter_if.slave  bus
);
  localparam int DATA_WIDTH = (2 ** (BYTE_ADDR_WIDTH - ADDR_WIDTH)) * 8;
  localparam int WB         = DATA_WIDTH / 8;
  localparam int OFFW       = BYTE_ADDR_WIDTH - ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, RESP} state_t;

  state_t                 state_q, state_d;
  logic [OFFW-1:0]        off_q, off_d;
  logic [2:0]             nb_q, nb_d;
  logic                   straddle_q, straddle_d;
  logic [ADDR_WIDTH-1:0]  widx_q, widx_d;
  logic [DATA_WIDTH-1:0]  word0_q, word0_d;
  logic                   nofill_q, nofill_d;
  logic                   cache_vld_q, cache_vld_d;
  logic [ADDR_WIDTH-1:0]  cache_tag_q, cache_tag_d;
  logic [DATA_WIDTH-1:0]  cache_data_q, cache_data_d;
  logic [31:0]            data_q, data_d;
  logic                   vld_q, vld_d;
  logic                   hit_q, hit_d;

  logic [OFFW-1:0]        req_off;
  logic [ADDR_WIDTH-1:0]  req_widx;
  logic [ADDR_WIDTH-1:0]  widx_nxt;
  logic [2:0]             req_nb;
  logic [OFFW:0]          req_end;
  logic                   req_straddle;
  logic                   req_hit;
  logic                   inv;
  logic [PLEN_WIDTH-1:0]  byte_len_w;

  // Shift the selected bytes to the top, take 32 bits, then drop the unused low bytes.
  function automatic logic [31:0] extract(input logic [2*DATA_WIDTH-1:0] cat,
                                          input logic [OFFW-1:0] off,
                                          input logic [2:0] nb);
    logic [2*DATA_WIDTH-1:0] sh;
    logic [31:0]             win;
    sh  = cat << {off, 3'b000};
    win = sh[2*DATA_WIDTH-1 -: 32];
    return win >> {3'd4 - nb, 3'b000};
  endfunction

  assign req_off      = bus.byte_rd_addr[OFFW-1:0];
  assign req_widx     = bus.byte_rd_addr[BYTE_ADDR_WIDTH-1:OFFW];
  assign req_end      = {1'b0, req_off} + (OFFW+1)'(req_nb);
  assign req_straddle = req_end > (OFFW+1)'(WB);
  assign widx_nxt     = widx_q + ADDR_WIDTH'(1);
  assign inv          = bus.cpu_acc | bus.cpu_rej;
  assign req_hit      = (CACHE_EN != 0) && cache_vld_q && (cache_tag_q == req_widx) && !req_straddle;

  always_comb begin
    case (bus.transfer_sz)
      2'b01:   req_nb = 3'd2;
      2'b10:   req_nb = 3'd1;
      default: req_nb = 3'd4;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    off_d            = off_q;
    nb_d             = nb_q;
    straddle_d       = straddle_q;
    widx_d           = widx_q;
    word0_d          = word0_q;
    nofill_d         = nofill_q;
    cache_vld_d      = cache_vld_q;
    cache_tag_d      = cache_tag_q;
    cache_data_d     = cache_data_q;
    data_d           = data_q;
    vld_d            = 1'b0;
    hit_d            = 1'b0;
    bus.rd_en        = 1'b0;
    bus.word_rd_addra = widx_q;
    bus.busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.cpu_rd_en) begin
          if (req_hit) begin
            vld_d  = 1'b1;
            hit_d  = 1'b1;
            data_d = extract({cache_data_q, {DATA_WIDTH{1'b0}}}, req_off, req_nb);
          end else begin
            bus.rd_en         = 1'b1;
            bus.word_rd_addra = req_widx;
            off_d             = req_off;
            nb_d              = req_nb;
            straddle_d        = req_straddle;
            widx_d            = req_widx;
            nofill_d          = inv;
            state_d           = WAIT0;
          end
        end
      end
      WAIT0: begin
        if (bus.bigword_vld) begin
          word0_d = bus.bigword;
          if (straddle_q) begin
            bus.rd_en         = 1'b1;
            bus.word_rd_addra = widx_nxt;
            state_d           = WAIT1;
          end else begin
            vld_d   = 1'b1;
            data_d  = extract({bus.bigword, {DATA_WIDTH{1'b0}}}, off_q, nb_q);
            state_d = RESP;
            if (!nofill_q) begin
              cache_vld_d  = 1'b1;
              cache_tag_d  = widx_q;
              cache_data_d = bus.bigword;
            end
          end
        end
      end
      WAIT1: begin
        if (bus.bigword_vld) begin
          vld_d   = 1'b1;
          data_d  = extract({word0_q, bus.bigword}, off_q, nb_q);
          state_d = RESP;
          if (!nofill_q) begin
            cache_vld_d  = 1'b1;
            cache_tag_d  = widx_nxt;
            cache_data_d = bus.bigword;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A retired packet poisons both the cache and any fill still in flight.
    if (inv && state_q != IDLE) nofill_d = 1'b1;
    if (inv || CACHE_EN == 0) cache_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= '0;
      nb_q         <= '0;
      straddle_q   <= 1'b0;
      widx_q       <= '0;
      word0_q      <= '0;
      nofill_q     <= 1'b0;
      cache_vld_q  <= 1'b0;
      cache_tag_q  <= '0;
      cache_data_q <= '0;
      data_q       <= '0;
      vld_q        <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      nb_q         <= nb_d;
      straddle_q   <= straddle_d;
      widx_q       <= widx_d;
      word0_q      <= word0_d;
      nofill_q     <= nofill_d;
      cache_vld_q  <= cache_vld_d;
      cache_tag_q  <= cache_tag_d;
      cache_data_q <= cache_data_d;
      data_q       <= data_d;
      vld_q        <= vld_d;
      hit_q        <= hit_d;
    end
  end

  assign bus.resized_mem_data     = data_q;
  assign bus.resized_mem_data_vld = vld_q;
  assign bus.cache_hit            = hit_q;

  assign byte_len_w       = bus.byte_len;
  assign bus.cpu_byte_len = byte_len_w;
  assign bus.acc          = bus.cpu_acc;
  assign bus.rej          = bus.cpu_rej;
  assign bus.rdy_ack      = bus.rdy_for_cpu_ack;
  assign bus.cpu_done_ack = bus.done_ack;
  assign bus.rdy_for_cpu  = bus.rdy;
endmodule

// File: tb/tb_cpu_rd_cache_adapter.sv
// Bench for cpu_rd_cache_adapter: vector table, hand-written corner sequences and a
// randomized phase checked against a byte-level memory/cache reference model.
module tb_cpu_rd_cache_adapter;
  logic clk;
  logic rst;

  cpu_rd_cache_adapter_if #(.BYTE_ADDR_WIDTH(12), .ADDR_WIDTH(9), .PLEN_WIDTH(32)) bus ();

  cpu_rd_cache_adapter #(.BYTE_ADDR_WIDTH(12), .ADDR_WIDTH(9), .PLEN_WIDTH(32), .CACHE_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int addr; int cnt; } pend_t;
  typedef struct {
    int          addr;
    int          sz;
    int          inv;
    logic [31:0] data;
    logic        hit;
    int          nrd;
  } vec_t;

  logic [63:0] mem [512];
  pend_t       pend[$];
  int          issued[$];
  int          lat_cur = 1;
  bit          inject = 0;
  int          vld_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Memory model: rd_en is seen on the rising edge, data returns lat_cur cycles later.
  initial forever begin
    @(posedge clk);
    if (!rst && bus.rd_en) begin
      pend.push_back('{int'(bus.word_rd_addra), lat_cur});
      issued.push_back(int'(bus.word_rd_addra));
    end
    if (bus.resized_mem_data_vld) vld_cnt++;
  end

  initial begin
    bus.bigword_vld = 1'b0;
    bus.bigword     = '0;
    forever begin
      @(negedge clk);
      bus.bigword_vld = 1'b0;
      if (inject) begin
        bus.bigword_vld = 1'b1;
        bus.bigword     = 64'hDEADBEEF_CAFEF00D;
        inject          = 0;
      end else if (pend.size() > 0) begin
        pend[0].cnt = pend[0].cnt - 1;
        if (pend[0].cnt == 0) begin
          bus.bigword_vld = 1'b1;
          bus.bigword     = mem[pend[0].addr];
          void'(pend.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] byte_at(input int a);
    logic [63:0] wd;
    int          p;
    wd = mem[(a / 8) % 512];
    p  = a % 8;
    return wd[8*(7-p) +: 8];
  endfunction

  function automatic logic [31:0] ref_bytes(input int a, input int nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r = (r << 8) | 32'(byte_at((a + i) % 4096));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle busy", 64'(bus.busy), 0);
  endtask

  task automatic pulse_inv(input int which);
    wait_idle();
    bus.cpu_acc = (which == 1);
    bus.cpu_rej = (which == 2);
    #1;
    chk("acc passthrough", 64'(bus.acc), 64'(which == 1));
    chk("rej passthrough", 64'(bus.rej), 64'(which == 2));
    @(negedge clk);
    bus.cpu_acc = 1'b0;
    bus.cpu_rej = 1'b0;
  endtask

  // acc_cyc: -1 none, 0 together with the request, k>0 during the k-th cycle after it.
  task automatic run_req(input string nm, input int a, input int sz, input int lat,
                         input logic [31:0] exp_data, input logic exp_hit,
                         input int exp_nrd, input int acc_cyc);
    int k;
    bit seen;
    int expl;
    int w;
    wait_idle();
    issued.delete();
    lat_cur          = lat;
    bus.byte_rd_addr = 12'(a);
    bus.transfer_sz  = 2'(sz);
    bus.cpu_rd_en    = 1'b1;
    bus.cpu_acc      = (acc_cyc == 0);
    @(negedge clk);
    bus.cpu_rd_en = 1'b0;
    bus.cpu_acc   = 1'b0;
    k    = 1;
    seen = 0;
    while (!seen && k <= 40) begin
      if (bus.resized_mem_data_vld) seen = 1;
      else begin
        if (k == acc_cyc) bus.cpu_acc = 1'b1;
        @(negedge clk);
        bus.cpu_acc = 1'b0;
        k++;
      end
    end
    expl = exp_hit ? 1 : ((exp_nrd == 2) ? 2*lat + 1 : lat + 1);
    chk({nm, " vld"}, 64'(seen), 1);
    if (seen) begin
      chk({nm, " data"}, 64'(bus.resized_mem_data), 64'(exp_data));
      chk({nm, " cache_hit"}, 64'(bus.cache_hit), 64'(exp_hit));
      chk({nm, " latency"}, 64'(k), 64'(expl));
    end
    chk({nm, " rd_cnt"}, 64'(issued.size()), 64'(exp_nrd));
    w = (a / 8) % 512;
    for (int i = 0; i < issued.size() && i < 2; i++)
      chk({nm, " rd_addr"}, 64'(issued[i]), 64'((w + i) % 512));
    $display("txn %s addr=%03h sz=%0d lat=%0d data=%08h hit=%0b cycles=%0d",
             nm, a, sz, lat, bus.resized_mem_data, bus.cache_hit, k);
  endtask

  initial begin
    int vc;
    int a, sz, lat, nb, w, off;
    bit str, mhit, mvalid;
    int mtag;

    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    mem[0]   = 64'h0011223344556677;
    mem[1]   = 64'h8899AABBCCDDEEFF;
    mem[511] = 64'hF0E1D2C3B4A59687;

    vecs[0]  = '{12'h002, 0, 0, 32'h22334455, 1'b0, 1};
    vecs[1]  = '{12'h007, 2, 0, 32'h00000077, 1'b1, 0};
    vecs[2]  = '{12'h006, 0, 0, 32'h66778899, 1'b0, 2};
    vecs[3]  = '{12'h009, 2, 0, 32'h00000099, 1'b1, 0};
    vecs[4]  = '{12'h00A, 2, 1, 32'h000000AA, 1'b0, 1};
    vecs[5]  = '{12'h001, 2, 0, 32'h00000011, 1'b0, 1};
    vecs[6]  = '{12'hFFF, 1, 0, 32'h00008700, 1'b0, 2};
    vecs[7]  = '{12'h004, 1, 0, 32'h00004455, 1'b1, 0};
    vecs[8]  = '{12'h004, 0, 0, 32'h44556677, 1'b1, 0};
    vecs[9]  = '{12'h005, 0, 0, 32'h55667788, 1'b0, 2};
    vecs[10] = '{12'h008, 2, 0, 32'h00000088, 1'b1, 0};
    vecs[11] = '{12'h008, 1, 2, 32'h00008899, 1'b0, 1};
    vecs[12] = '{12'h00F, 2, 0, 32'h000000FF, 1'b1, 0};

    rst                 = 1'b1;
    bus.byte_rd_addr    = '0;
    bus.cpu_rd_en       = 1'b0;
    bus.transfer_sz     = 2'b00;
    bus.cpu_acc         = 1'b0;
    bus.cpu_rej         = 1'b0;
    bus.rdy_for_cpu_ack = 1'b1;
    bus.done_ack        = 1'b1;
    bus.rdy             = 1'b0;
    bus.byte_len        = 32'd1234;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rd_en", 64'(bus.rd_en), 0);
    chk("reset busy", 64'(bus.busy), 0);
    chk("reset data", 64'(bus.resized_mem_data), 0);
    chk("reset vld", 64'(bus.resized_mem_data_vld), 0);
    chk("reset cache_hit", 64'(bus.cache_hit), 0);
    chk("rdy_ack passthrough", 64'(bus.rdy_ack), 1);
    chk("done_ack passthrough", 64'(bus.cpu_done_ack), 1);
    chk("rdy passthrough", 64'(bus.rdy_for_cpu), 0);
    chk("byte_len passthrough", 64'(bus.cpu_byte_len), 64'd1234);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].inv != 0) pulse_inv(vecs[i].inv);
      run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].sz, 2,
              vecs[i].data, vecs[i].hit, vecs[i].nrd, -1);
    end

    // A hit alongside acc is served, but the line is gone afterwards.
    run_req("acc_with_hit", 12'h00C, 2, 2, 32'h000000CC, 1'b1, 0, 0);
    run_req("after_acc_hit", 12'h00C, 2, 2, 32'h000000CC, 1'b0, 1, -1);

    // acc while waiting for memory: read completes, nothing is cached.
    run_req("acc_in_wait", 12'h018, 0, 3, ref_bytes(12'h018, 4), 1'b0, 1, 2);
    run_req("after_acc_wait", 12'h018, 0, 1, ref_bytes(12'h018, 4), 1'b0, 1, -1);
    run_req("refill_hit", 12'h01A, 1, 1, ref_bytes(12'h01A, 2), 1'b1, 0, -1);

    // Request while busy is dropped.
    wait_idle();
    issued.delete();
    lat_cur          = 3;
    vc               = vld_cnt;
    bus.byte_rd_addr = 12'h020;
    bus.transfer_sz  = 2'b10;
    bus.cpu_rd_en    = 1'b1;
    @(negedge clk);
    chk("busy during miss", 64'(bus.busy), 1);
    bus.byte_rd_addr = 12'h028;
    @(negedge clk);
    bus.cpu_rd_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy drop rd_cnt", 64'(issued.size()), 1);
    if (issued.size() > 0) chk("busy drop rd_addr", 64'(issued[0]), 4);
    chk("busy drop vld_cnt", 64'(vld_cnt - vc), 1);
    chk("busy drop data", 64'(bus.resized_mem_data), 64'(ref_bytes(12'h020, 1)));
    $display("txn busy_drop issued=%0d vlds=%0d", issued.size(), vld_cnt - vc);

    // Stray bigword_vld in IDLE must be ignored.
    vc     = vld_cnt;
    inject = 1;
    repeat (5) @(negedge clk);
    chk("stray vld no output", 64'(vld_cnt - vc), 0);
    chk("stray vld not busy", 64'(bus.busy), 0);
    $display("txn stray_bigword_vld vlds=%0d", vld_cnt - vc);
    run_req("hit_after_stray", 12'h023, 2, 1, ref_bytes(12'h023, 1), 1'b1, 0, -1);

    // Async reset while waiting for the second word of a straddle.
    wait_idle();
    issued.delete();
    lat_cur          = 3;
    bus.byte_rd_addr = 12'h016;
    bus.transfer_sz  = 2'b00;
    bus.cpu_rd_en    = 1'b1;
    @(negedge clk);
    bus.cpu_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy in wait1", 64'(bus.busy), 1);
    chk("wait1 rd_cnt", 64'(issued.size()), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy", 64'(bus.busy), 0);
    chk("rst data", 64'(bus.resized_mem_data), 0);
    pend.delete();
    vc = vld_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst no vld", 64'(vld_cnt - vc), 0);
    $display("txn reset_in_wait1 vlds=%0d", vld_cnt - vc);
    run_req("post_rst_read", 12'h016, 0, 2, ref_bytes(12'h016, 4), 1'b0, 2, -1);

    // Randomized phase against the reference model.
    pulse_inv(1);
    mvalid = 0;
    mtag   = 0;
    for (int t = 0; t < 60; t++) begin
      a   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 47)) : int'($urandom_range(4080, 4095));
      sz  = int'($urandom_range(0, 2));
      lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) begin
        pulse_inv(int'($urandom_range(1, 2)));
        mvalid = 0;
      end
      nb   = (sz == 0) ? 4 : (sz == 1) ? 2 : 1;
      w    = a / 8;
      off  = a % 8;
      str  = (off + nb) > 8;
      mhit = mvalid && (mtag == w) && !str;
      run_req($sformatf("rnd%0d", t), a, sz, lat, ref_bytes(a, nb), mhit,
              mhit ? 0 : (str ? 2 : 1), -1);
      if (!mhit) begin
        mvalid = 1;
        mtag   = str ? (w + 1) % 512 : w;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
